// File: rtl/r_backward_demux.sv
// Routes merged read beats to two return ports by an ID bit, one FIFO per port.
// Latency: 1 cycle from input acceptance to output valid; no combinational S->M path.
// Backpressure: S_READY drops only when the selected port's FIFO is full; ports stall independently.
module r_backward_demux #(
  parameter int DW       = 14,
  parameter int ID_BIT   = 12,
  parameter int LAST_BIT = 13,
  parameter int DEPTH    = 2,
  parameter int CW       = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic [DW-1:0] S_DATA,
  input  logic          S_VALID,
  output logic          S_READY,
  output logic [DW-1:0] M0_DATA,
  output logic          M0_VALID,
  input  logic          M0_READY,
  output logic [DW-1:0] M1_DATA,
  output logic          M1_VALID,
  input  logic          M1_READY,
  output logic [CW-1:0] M0_BURSTS,
  output logic [CW-1:0] M1_BURSTS,
  output logic          BURST_ERR
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem0 [DEPTH];
  logic [DW-1:0]   mem1 [DEPTH];
  logic [AW-1:0]   wr0, wr1, rd0, rd1;
  logic [CNTW-1:0] cnt0, cnt1;
  logic            in_burst0, in_burst1;
  logic            sel, full0, full1;
  logic            accept, push0, push1, pop0, pop1, last_in;

  // Steering and handshake decode; the ready never looks at the pop side,
  // so a full FIFO refuses a beat even when it is draining this cycle.
  always_comb begin
    sel      = S_DATA[ID_BIT];
    last_in  = S_DATA[LAST_BIT];
    full0    = (cnt0 == CNTW'(DEPTH));
    full1    = (cnt1 == CNTW'(DEPTH));
    S_READY  = sel ? !full1 : !full0;
    accept   = S_VALID && S_READY;
    push0    = accept && !sel;
    push1    = accept && sel;
    M0_VALID = (cnt0 != '0);
    M1_VALID = (cnt1 != '0);
    M0_DATA  = mem0[rd0];
    M1_DATA  = mem1[rd1];
    pop0     = M0_VALID && M0_READY;
    pop1     = M1_VALID && M1_READY;
  end

  // Beat storage; contents are meaningless while the matching count is zero,
  // so it carries no reset.
  always_ff @(posedge CLK) begin
    if (push0) mem0[wr0] <= S_DATA;
    if (push1) mem1[wr1] <= S_DATA;
  end

  // Port 0 pointers, occupancy and popped-burst counter.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr0       <= '0;
      rd0       <= '0;
      cnt0      <= '0;
      M0_BURSTS <= '0;
    end else begin
      if (push0) wr0 <= wr0 + AW'(1);
      if (pop0)  rd0 <= rd0 + AW'(1);
      case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + CNTW'(1);
        2'b01:   cnt0 <= cnt0 - CNTW'(1);
        default: cnt0 <= cnt0;
      endcase
      if (pop0 && M0_DATA[LAST_BIT]) M0_BURSTS <= M0_BURSTS + CW'(1);
    end
  end

  // Port 1 pointers, occupancy and popped-burst counter.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr1       <= '0;
      rd1       <= '0;
      cnt1      <= '0;
      M1_BURSTS <= '0;
    end else begin
      if (push1) wr1 <= wr1 + AW'(1);
      if (pop1)  rd1 <= rd1 + AW'(1);
      case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + CNTW'(1);
        2'b01:   cnt1 <= cnt1 - CNTW'(1);
        default: cnt1 <= cnt1;
      endcase
      if (pop1 && M1_DATA[LAST_BIT]) M1_BURSTS <= M1_BURSTS + CW'(1);
    end
  end

  // Input-side burst tracking; a beat to one port while the other port's
  // burst is still open is an interleave violation, latched until reset.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      in_burst0 <= 1'b0;
      in_burst1 <= 1'b0;
      BURST_ERR <= 1'b0;
    end else begin
      if (push0) in_burst0 <= !last_in;
      if (push1) in_burst1 <= !last_in;
      if ((push0 && in_burst1) || (push1 && in_burst0)) BURST_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r_backward_demux.sv
// Randomized and directed bench for r_backward_demux with a queue-based reference model.
// Latency: model queues updated at each rising edge; outputs compared on falling edges.
// Backpressure: M0_READY/M1_READY driven independently, including long stalls.
module tb_r_backward_demux;

  localparam int DW    = 14;
  localparam int CW    = 4;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic [DW-1:0] S_DATA = '0;
  logic          S_VALID = 1'b0;
  logic          S_READY;
  logic [DW-1:0] M0_DATA, M1_DATA;
  logic          M0_VALID, M1_VALID;
  logic          M0_READY = 1'b0;
  logic          M1_READY = 1'b0;
  logic [CW-1:0] M0_BURSTS, M1_BURSTS;
  logic          BURST_ERR;

  int errors = 0;
  int checks = 0;

  // Reference model: plain queues, flags and modular counters.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit ib0, ib1, merr;
  int b0, b1;

  r_backward_demux #(.DW(DW), .ID_BIT(12), .LAST_BIT(13), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M0_DATA(M0_DATA), .M0_VALID(M0_VALID), .M0_READY(M0_READY),
    .M1_DATA(M1_DATA), .M1_VALID(M1_VALID), .M1_READY(M1_READY),
    .M0_BURSTS(M0_BURSTS), .M1_BURSTS(M1_BURSTS), .BURST_ERR(BURST_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ib0 = 0; ib1 = 0; merr = 0; b0 = 0; b1 = 0;
  endtask

  // Compare the DUT against the model, then advance the model across the next edge.
  logic          m_acc, m_p0, m_p1, m_sel;
  logic [DW-1:0] m_d;
  always @(negedge CLK) begin
    if (RESETn) begin
      m_sel = S_DATA[12];
      chk("m0_valid", {31'd0, M0_VALID}, {31'd0, q0.size() != 0});
      chk("m1_valid", {31'd0, M1_VALID}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) chk("m0_data", {18'd0, M0_DATA}, {18'd0, q0[0]});
      if (q1.size() != 0) chk("m1_data", {18'd0, M1_DATA}, {18'd0, q1[0]});
      chk("s_ready", {31'd0, S_READY},
          {31'd0, m_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)});
      chk("m0_bursts", {28'd0, M0_BURSTS}, b0);
      chk("m1_bursts", {28'd0, M1_BURSTS}, b1);
      chk("burst_err", {31'd0, BURST_ERR}, {31'd0, merr});
      m_acc = S_VALID && (m_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      m_p0  = (q0.size() != 0) && M0_READY;
      m_p1  = (q1.size() != 0) && M1_READY;
      m_d   = S_DATA;
      @(posedge CLK);
      if (RESETn) begin
        if (m_p0) begin
          if (q0[0][13]) b0 = (b0 + 1) % 16;
          void'(q0.pop_front());
        end
        if (m_p1) begin
          if (q1[0][13]) b1 = (b1 + 1) % 16;
          void'(q1.pop_front());
        end
        if (m_acc) begin
          if (m_sel ? ib0 : ib1) merr = 1;
          if (m_sel) begin q1.push_back(m_d); ib1 = !m_d[13]; end
          else       begin q0.push_back(m_d); ib0 = !m_d[13]; end
        end
      end
    end
  end

  // Apply inputs, let one rising edge pass, return just after it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r0, input logic r1);
    S_VALID  = v;
    S_DATA   = d;
    M0_READY = r0;
    M1_READY = r1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    S_VALID = 0; M0_READY = 0; M1_READY = 0;
    #3;
    RESETn = 0;
    model_clear();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESETn = 1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(posedge CLK);
    #1;
    chk("rst_m0_valid", {31'd0, M0_VALID}, 0);
    chk("rst_m1_valid", {31'd0, M1_VALID}, 0);
    chk("rst_burst_err", {31'd0, BURST_ERR}, 0);
    @(posedge CLK);
    #1;
    RESETn = 1;
    #1;
    chk("rst_s_ready", {31'd0, S_READY}, 1);

    // Basic routing
    step(1, 14'h0005, 1, 0);
    chk("basic_m0_first", {18'd0, M0_DATA}, 32'h0005);
    step(1, 14'h2006, 1, 0);
    chk("basic_m0_second", {18'd0, M0_DATA}, 32'h2006);
    step(0, 0, 1, 0);
    chk("basic_bursts", {28'd0, M0_BURSTS}, 1);
    chk("basic_m1_idle", {31'd0, M1_VALID}, 0);
    chk("basic_err", {31'd0, BURST_ERR}, 0);

    // Back-pressure isolation
    do_reset();
    step(1, 14'h1001, 1, 0);
    step(1, 14'h1002, 1, 0);
    S_DATA = 14'h1003; S_VALID = 1; #1;
    chk("bp_blocked", {31'd0, S_READY}, 0);
    step(1, 14'h1003, 1, 0);
    S_DATA = 14'h0003; #1;
    chk("bp_other_ready", {31'd0, S_READY}, 1);
    step(1, 14'h0003, 0, 0);
    chk("bp_m0_data", {18'd0, M0_DATA}, 32'h0003);
    chk("bp_m1_head", {18'd0, M1_DATA}, 32'h1001);
    step(0, 0, 1, 1);
    chk("bp_m1_drain", {18'd0, M1_DATA}, 32'h1002);
    step(0, 0, 1, 1);
    chk("bp_m1_empty", {31'd0, M1_VALID}, 0);

    // Full boundary: no pass-through while draining
    do_reset();
    step(1, 14'h0001, 0, 0);
    step(1, 14'h0002, 0, 0);
    S_DATA = 14'h0004; M0_READY = 1; #1;
    chk("full_no_pass", {31'd0, S_READY}, 0);
    step(1, 14'h0004, 1, 0);
    chk("full_next_ready", {31'd0, S_READY}, 1);
    step(1, 14'h0004, 1, 0);
    step(0, 0, 0, 0);
    chk("full_accepted", {18'd0, M0_DATA}, 32'h0004);

    // Interleave error
    do_reset();
    step(1, 14'h0010, 0, 0);
    chk("il_err_before", {31'd0, BURST_ERR}, 0);
    step(1, 14'h3011, 0, 0);
    chk("il_err_set", {31'd0, BURST_ERR}, 1);
    chk("il_m0", {18'd0, M0_DATA}, 32'h0010);
    chk("il_m1", {18'd0, M1_DATA}, 32'h3011);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("il_err_held", {31'd0, BURST_ERR}, 1);

    // Counter wrap on port 1
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 14'h3000 | 14'(i), 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrap_m1_bursts", {28'd0, M1_BURSTS}, 1);

    // Reset mid-burst
    do_reset();
    step(1, 14'h2030, 0, 0);
    step(0, 0, 1, 0);
    step(1, 14'h0020, 0, 0);
    step(1, 14'h1021, 0, 0);
    chk("mid_err_pre", {31'd0, BURST_ERR}, 1);
    chk("mid_bursts_pre", {28'd0, M0_BURSTS}, 1);
    #2;
    RESETn = 0;
    model_clear();
    #1;
    chk("mid_m0_valid", {31'd0, M0_VALID}, 0);
    chk("mid_m1_valid", {31'd0, M1_VALID}, 0);
    chk("mid_err", {31'd0, BURST_ERR}, 0);
    chk("mid_bursts", {28'd0, M0_BURSTS}, 0);
    @(posedge CLK);
    #1;
    RESETn = 1;
    step(0, 0, 1, 1);
    chk("mid_s_ready", {31'd0, S_READY}, 1);
    chk("mid_no_stale", {31'd0, M0_VALID | M1_VALID}, 0);

    // Randomized traffic with periodic resets
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 3) != 0, 14'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
    end

    S_VALID = 0;
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
